// File: rtl/cmd_arbiter.sv
// Round-robin arbiter that merges NUM_REQ fire-and-forget command strobes into one
// valid/ready command port, with a one-entry pending slot per requester and a held output stage.
module cmd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CMD_W   = 3,
    parameter int ARG_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
    input  logic [NUM_REQ*ARG_W-1:0]   req_arg0,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_pending,
    output logic [NUM_REQ-1:0]         overflow,
    input  logic                       overflow_clear,
    output logic [CMD_W-1:0]           cmd,
    output logic [ARG_W-1:0]           cmd_arg0,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [CMD_W-1:0]   in_cmd [NUM_REQ];
    logic [ARG_W-1:0]   in_arg [NUM_REQ];

    logic [NUM_REQ-1:0] slot_vld_q, slot_vld_d;
    logic [CMD_W-1:0]   slot_cmd_q [NUM_REQ];
    logic [CMD_W-1:0]   slot_cmd_d [NUM_REQ];
    logic [ARG_W-1:0]   slot_arg_q [NUM_REQ];
    logic [ARG_W-1:0]   slot_arg_d [NUM_REQ];
    logic [NUM_REQ-1:0] ovf_q, ovf_d;

    logic               cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [ARG_W-1:0]   arg_q, arg_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic               out_free;
    logic               gnt_found;
    logic               grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign in_cmd[g] = req_cmd[g*CMD_W +: CMD_W];
        assign in_arg[g] = req_arg0[g*ARG_W +: ARG_W];
    end

    assign out_free = !cmd_valid_q || cmd_ready;

    // Two descending passes: the last hit wins, so the lowest index above last_q
    // beats any index at or below it, giving the last+1, last+2, ... scan order.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (slot_vld_q[IDX_W'(j)] && (j <= int'(last_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (slot_vld_q[IDX_W'(j)] && (j > int'(last_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(j);
            end
        end
    end

    assign grant = out_free && gnt_found;

    always_comb begin
        gnt_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_oh[IDX_W'(j)] = grant && (gnt_idx == IDX_W'(j));
        end
    end

    // A slot being granted this cycle counts as empty, so a same-cycle strobe refills it.
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_cmd_d = slot_cmd_q;
        slot_arg_d = slot_arg_q;
        ovf_d      = overflow_clear ? '0 : ovf_q;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_oh[IDX_W'(j)]) begin
                slot_vld_d[IDX_W'(j)] = 1'b0;
            end
            if (req_valid[IDX_W'(j)]) begin
                if (!slot_vld_q[IDX_W'(j)] || gnt_oh[IDX_W'(j)]) begin
                    slot_vld_d[IDX_W'(j)] = 1'b1;
                    slot_cmd_d[IDX_W'(j)] = in_cmd[IDX_W'(j)];
                    slot_arg_d[IDX_W'(j)] = in_arg[IDX_W'(j)];
                end else begin
                    ovf_d[IDX_W'(j)] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        gid_d       = gid_q;
        last_d      = last_q;
        if (grant) begin
            cmd_valid_d = 1'b1;
            cmd_d       = slot_cmd_q[gnt_idx];
            arg_d       = slot_arg_q[gnt_idx];
            gid_d       = gnt_idx;
            last_d      = gnt_idx;
        end else if (out_free) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_vld_q  <= '0;
            slot_cmd_q  <= '{default: '0};
            slot_arg_q  <= '{default: '0};
            ovf_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            arg_q       <= '0;
            gid_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_cmd_q  <= slot_cmd_d;
            slot_arg_q  <= slot_arg_d;
            ovf_q       <= ovf_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            gid_q       <= gid_d;
            last_q      <= last_d;
        end
    end

    assign req_pending = slot_vld_q;
    assign overflow    = ovf_q;
    assign cmd         = cmd_q;
    assign cmd_arg0    = arg_q;
    assign cmd_valid   = cmd_valid_q;
    assign grant_id    = gid_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: expected commands are queued as they are strobed in and
// popped by a monitor at every engine handshake; scenario tasks also check state inline.
module tb_cmd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int CMD_W   = 3;
    localparam int ARG_W   = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ*ARG_W-1:0] req_arg0;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_pending;
    logic [NUM_REQ-1:0]       overflow;
    logic                     overflow_clear;
    logic [CMD_W-1:0]         cmd;
    logic [ARG_W-1:0]         cmd_arg0;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [0:0]               grant_id;

    typedef struct packed {
        logic [0:0]       id;
        logic [CMD_W-1:0] cmd;
        logic [ARG_W-1:0] arg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_hs   = 0;
    int   h0;

    cmd_arbiter #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .ARG_W(ARG_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_cmd       (req_cmd),
        .req_arg0      (req_arg0),
        .req_valid     (req_valid),
        .req_pending   (req_pending),
        .overflow      (overflow),
        .overflow_clear(overflow_clear),
        .cmd           (cmd),
        .cmd_arg0      (cmd_arg0),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    // Every accepted command must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            n_hs++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL handshake_unexpected: got id=%0d cmd=%0d arg=%h, required no handshake",
                         grant_id, cmd, cmd_arg0);
            end else begin
                mon_e = sb.pop_front();
                if ({grant_id, cmd, cmd_arg0} !== mon_e) begin
                    n_fail++;
                    $display("FAIL handshake_data: got id=%0d cmd=%0d arg=%h, required id=%0d cmd=%0d arg=%h",
                             grant_id, cmd, cmd_arg0, mon_e.id, mon_e.cmd, mon_e.arg);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int r, input logic [CMD_W-1:0] c, input logic [ARG_W-1:0] a,
                          input bit push);
        exp_t e;
        req_cmd[r*CMD_W +: CMD_W]  = c;
        req_arg0[r*ARG_W +: ARG_W] = a;
        req_valid[r]               = 1'b1;
        if (push) begin
            e.id  = 1'(r);
            e.cmd = c;
            e.arg = a;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        req_cmd        = '0;
        req_arg0       = '0;
        req_valid      = '0;
        overflow_clear = 1'b0;
        cmd_ready      = 1'b0;
        step();
        step();
        n_cmp++;
        if ({cmd_valid, cmd, cmd_arg0, grant_id, req_pending, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b cmd=%0d arg=%h id=%0d pend=%b ovf=%b, required all 0",
                     cmd_valid, cmd, cmd_arg0, grant_id, req_pending, overflow);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        cmd_ready = 1'b1;
        strobe(0, 3'd2, 32'h0000_0042, 1);
        step();
        req_valid = '0;
        n_cmp++;
        if (req_pending !== 2'b01 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: got pend=%b valid=%b, required pend=01 valid=0", req_pending, cmd_valid);
        end
        step();
        h0 = n_hs;
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd2 || cmd_arg0 !== 32'h42 || grant_id !== 1'b0 ||
            req_pending !== 2'b00) begin
            n_fail++;
            $display("FAIL single_t2: got valid=%b cmd=%0d arg=%h id=%0d pend=%b, required 1 2 42 0 00",
                     cmd_valid, cmd, cmd_arg0, grant_id, req_pending);
        end
        step();
        n_cmp++;
        if (cmd_valid !== 1'b0 || n_hs - h0 != 1) begin
            n_fail++;
            $display("FAIL single_done: got valid=%b handshakes=%0d, required valid=0 handshakes=1",
                     cmd_valid, n_hs - h0);
        end
    endtask

    task automatic test_contention();
        do_reset();
        cmd_ready = 1'b1;
        strobe(0, 3'd1, 32'h11, 1);
        strobe(1, 3'd5, 32'h22, 1);
        step();
        req_valid = '0;
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1 || grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_first: got valid=%b id=%0d, required valid=1 id=0", cmd_valid, grant_id);
        end
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1 || grant_id !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_second: got valid=%b id=%0d, required valid=1 id=1", cmd_valid, grant_id);
        end
        step();
        strobe(0, 3'd7, 32'h33, 1);
        step();
        req_valid = '0;
        step();
        step();
        strobe(1, 3'd5, 32'h44, 1);
        strobe(0, 3'd1, 32'h55, 1);
        step();
        req_valid = '0;
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1 || grant_id !== 1'b1) begin
            n_fail++;
            $display("FAIL rotate_first: got valid=%b id=%0d, required valid=1 id=1", cmd_valid, grant_id);
        end
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1 || grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rotate_second: got valid=%b id=%0d, required valid=1 id=0", cmd_valid, grant_id);
        end
        step();
        n_cmp++;
        if (cmd_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL contention_drain: got valid=%b queued=%0d, required 0 0", cmd_valid, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad       = 0;
        cmd_ready = 1'b0;
        strobe(1, 3'd6, 32'hDEAD_BEEF, 1);
        step();
        req_valid = '0;
        step();
        strobe(0, 3'd3, 32'h123, 1);
        for (int k = 0; k < 10; k++) begin
            step();
            req_valid = '0;
            if (cmd_valid !== 1'b1 || cmd !== 3'd6 || cmd_arg0 !== 32'hDEAD_BEEF || grant_id !== 1'b1)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d unstable cycles (last valid=%b cmd=%0d arg=%h id=%0d), required 0",
                     bad, cmd_valid, cmd, cmd_arg0, grant_id);
        end
        n_cmp++;
        if (req_pending !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_pending: got %b, required 01", req_pending);
        end
        h0        = n_hs;
        cmd_ready = 1'b1;
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1 || grant_id !== 1'b0 || cmd !== 3'd3) begin
            n_fail++;
            $display("FAIL backpressure_next: got valid=%b id=%0d cmd=%0d, required 1 0 3", cmd_valid, grant_id, cmd);
        end
        step();
        n_cmp++;
        if (cmd_valid !== 1'b0 || n_hs - h0 != 2) begin
            n_fail++;
            $display("FAIL backpressure_count: got valid=%b handshakes=%0d, required 0 2", cmd_valid, n_hs - h0);
        end
    endtask

    task automatic test_overflow();
        cmd_ready = 1'b0;
        strobe(0, 3'd1, 32'hA0, 1);
        step();
        req_valid = '0;
        step();
        strobe(1, 3'd3, 32'hB3, 1);
        step();
        strobe(1, 3'd4, 32'hB4, 0);
        step();
        req_valid = '0;
        n_cmp++;
        if (overflow !== 2'b10 || req_pending !== 2'b10) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b pend=%b, required 10 10", overflow, req_pending);
        end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        n_cmp++;
        if (overflow !== 2'b00) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b, required 00", overflow);
        end
        strobe(1, 3'd5, 32'hB5, 0);
        overflow_clear = 1'b1;
        step();
        req_valid      = '0;
        overflow_clear = 1'b0;
        n_cmp++;
        if (overflow !== 2'b10) begin
            n_fail++;
            $display("FAIL overflow_set_wins: got %b, required 10", overflow);
        end
        h0        = n_hs;
        cmd_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (cmd_valid !== 1'b0 || n_hs - h0 != 2) begin
            n_fail++;
            $display("FAIL overflow_drain: got valid=%b handshakes=%0d, required 0 2", cmd_valid, n_hs - h0);
        end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
    endtask

    task automatic test_refill();
        cmd_ready = 1'b1;
        h0        = n_hs;
        strobe(0, 3'd2, 32'h1, 1);
        step();
        strobe(0, 3'd6, 32'h2, 1);
        step();
        req_valid = '0;
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd2 || req_pending !== 2'b01) begin
            n_fail++;
            $display("FAIL refill_first: got valid=%b cmd=%0d pend=%b, required 1 2 01", cmd_valid, cmd, req_pending);
        end
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd6 || req_pending !== 2'b00) begin
            n_fail++;
            $display("FAIL refill_second: got valid=%b cmd=%0d pend=%b, required 1 6 00", cmd_valid, cmd, req_pending);
        end
        step();
        n_cmp++;
        if (cmd_valid !== 1'b0 || n_hs - h0 != 2) begin
            n_fail++;
            $display("FAIL refill_count: got valid=%b handshakes=%0d, required 0 2", cmd_valid, n_hs - h0);
        end
    endtask

    task automatic test_reset_mid();
        cmd_ready = 1'b0;
        strobe(0, 3'd2, 32'hAA, 0);
        step();
        req_valid = '0;
        step();
        strobe(0, 3'd3, 32'hBB, 0);
        strobe(1, 3'd4, 32'hCC, 0);
        step();
        req_valid = '0;
        n_cmp++;
        if (req_pending !== 2'b11 || cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: got pend=%b valid=%b, required 11 1", req_pending, cmd_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_valid, cmd, cmd_arg0, grant_id, req_pending, overflow} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%b cmd=%0d arg=%h id=%0d pend=%b ovf=%b, required all 0",
                     cmd_valid, cmd, cmd_arg0, grant_id, req_pending, overflow);
        end
        sb.delete();
        step();
        reset     = 1'b0;
        cmd_ready = 1'b1;
        h0        = n_hs;
        step();
        step();
        step();
        n_cmp++;
        if (cmd_valid !== 1'b0 || n_hs != h0) begin
            n_fail++;
            $display("FAIL midreset_nothing: got valid=%b handshakes=%0d, required 0 0", cmd_valid, n_hs - h0);
        end
        strobe(0, 3'd1, 32'h10, 1);
        strobe(1, 3'd7, 32'h20, 1);
        step();
        req_valid = '0;
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1 || grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_priority: got valid=%b id=%0d, required 1 0", cmd_valid, grant_id);
        end
        step();
        step();
        n_cmp++;
        if (cmd_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_drain: got valid=%b queued=%0d, required 0 0", cmd_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overflow();
        test_refill();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d undelivered, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
